// File: rtl/ipg_pkg.sv
// Shared definitions for the 10GBASE-R IPG side-channel inserter/extractor:
// block types, sync headers, IPG field layout and block classification.
`timescale 1ns/1ps
package ipg_pkg;

  localparam logic [1:0] HDR_DATA = 2'b01;
  localparam logic [1:0] HDR_CTRL = 2'b10;

  localparam logic [7:0] TYPE_IDLE     = 8'h1E;
  localparam logic [7:0] TYPE_START_0  = 8'h78;
  localparam logic [7:0] TYPE_START_4  = 8'h33;
  localparam logic [7:0] TYPE_START_4B = 8'h66;
  localparam logic [7:0] TYPE_TERM_0   = 8'h87;
  localparam logic [7:0] TYPE_TERM_1   = 8'h99;
  localparam logic [7:0] TYPE_TERM_2   = 8'hAA;
  localparam logic [7:0] TYPE_TERM_3   = 8'hB4;
  localparam logic [7:0] TYPE_TERM_4   = 8'hCC;
  localparam logic [7:0] TYPE_TERM_5   = 8'hD2;
  // The T6 code 0xE1 is reused as the IPG marker, so it is not a terminate here.
  localparam logic [7:0] TYPE_TERM_7   = 8'hFF;
  localparam logic [7:0] IPG_TYPE_DEFAULT = 8'hE1;

  localparam logic [63:0] IDLE_BLOCK = 64'h0000_0000_0000_001E;

  localparam int IPG_TYPE_LSB     = 0;
  localparam int IPG_LEN_LSB      = 8;
  localparam int IPG_LEN_BITS     = 6;
  localparam int IPG_PAYLOAD_LSB  = 16;
  localparam int IPG_PAYLOAD_BITS = 48;

  typedef enum logic [2:0] {
    CLS_IDLE,
    CLS_START,
    CLS_TERM,
    CLS_OTHER_CTRL,
    CLS_DATA,
    CLS_BAD_HDR
  } blk_class_e;

  typedef enum logic [1:0] {
    ST_GAP,
    ST_FRAME,
    ST_GUARD
  } tx_state_e;

  typedef struct packed {
    logic                        is_null;
    logic [IPG_LEN_BITS-1:0]     len;
    logic [IPG_PAYLOAD_BITS-1:0] data;
  } ipg_entry_t;

  function automatic blk_class_e classify(input logic [63:0] data, input logic [1:0] hdr);
    blk_class_e cls;
    cls = CLS_BAD_HDR;
    if (hdr == HDR_DATA) begin
      cls = CLS_DATA;
    end else if (hdr == HDR_CTRL) begin
      case (data[7:0])
        TYPE_IDLE:
          cls = (data[63:8] == '0) ? CLS_IDLE : CLS_OTHER_CTRL;
        TYPE_START_0, TYPE_START_4, TYPE_START_4B:
          cls = CLS_START;
        TYPE_TERM_0, TYPE_TERM_1, TYPE_TERM_2, TYPE_TERM_3,
        TYPE_TERM_4, TYPE_TERM_5, TYPE_TERM_7:
          cls = CLS_TERM;
        default:
          cls = CLS_OTHER_CTRL;
      endcase
    end
    return cls;
  endfunction

  // Payload bits at or above len are forced to zero so the receiver sees clean padding.
  function automatic logic [63:0] ipg_block(input logic [7:0]                  blk_type,
                                            input logic [IPG_LEN_BITS-1:0]     len,
                                            input logic [IPG_PAYLOAD_BITS-1:0] payload);
    logic [IPG_PAYLOAD_BITS-1:0] mask;
    mask = (len >= 6'd48) ? '1 : ((48'd1 << len) - 48'd1);
    return {payload & mask, 2'b00, len, blk_type};
  endfunction

endpackage

// File: rtl/ipg_tx_if.sv
// Side-channel word handshake between a user source and ipg_tx.
`timescale 1ns/1ps
interface ipg_tx_if;
  import ipg_pkg::*;

  logic [63:0]             tx_ipg_data;
  logic [IPG_LEN_BITS-1:0] tx_ipg_len;
  logic                    tx_ipg_valid;
  logic                    tx_ipg_ready;

  modport master (
    output tx_ipg_data, tx_ipg_len, tx_ipg_valid,
    input  tx_ipg_ready
  );

  modport slave (
    input  tx_ipg_data, tx_ipg_len, tx_ipg_valid,
    output tx_ipg_ready
  );
endinterface

// File: rtl/ipg_tx_fifo.sv
// Small synchronous FIFO of side-channel entries; ready is a registered !full
// that is held low while in reset.
`timescale 1ns/1ps
module ipg_tx_fifo
  import ipg_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  ipg_entry_t push_entry,
  input  logic       pop,
  output ipg_entry_t head,
  output logic       full,
  output logic       empty,
  output logic       ready
);

  localparam int             AW        = $clog2(DEPTH);
  localparam logic [AW:0]    DEPTH_CNT = (AW+1)'(DEPTH);

  ipg_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    // NOTE: default assignment first so every path drives count_nxt and no latch is inferred.
    count_nxt = count;
    case ({do_push, do_pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments for all registered state, so every flop samples pre-edge values.
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ready  <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      ready <= (count_nxt != DEPTH_CNT);
    end
  end

  // NOTE: storage is not reset; the pointers and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/ipg_tx.sv
// TX-side IPG inserter: replaces eligible all-idle blocks in the inter-packet gap
// with IPG blocks carrying buffered side-channel words; one cycle of latency.
`timescale 1ns/1ps
module ipg_tx
  import ipg_pkg::*;
#(
  parameter int         DATA_WIDTH     = 64,
  parameter int         HDR_WIDTH      = 2,
  parameter int         FIFO_DEPTH     = 4,
  parameter int         GUARD_BLOCKS   = 1,
  parameter logic [7:0] IPG_BLOCK_TYPE = IPG_TYPE_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] encoded_tx_data,
  input  logic [HDR_WIDTH-1:0]  encoded_tx_hdr,
  output logic [DATA_WIDTH-1:0] out_tx_data,
  output logic [HDR_WIDTH-1:0]  out_tx_hdr,
  ipg_tx_if.slave               side,
  output logic                  tx_ipg_inserted,
  output logic                  tx_ipg_len_err,
  output logic [15:0]           tx_ipg_count
);

  if (DATA_WIDTH != 64) begin : g_bad_data_width
    $fatal(1, "ipg_tx: DATA_WIDTH must be 64");
  end
  if (HDR_WIDTH != 2) begin : g_bad_hdr_width
    $fatal(1, "ipg_tx: HDR_WIDTH must be 2");
  end
  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $fatal(1, "ipg_tx: FIFO_DEPTH must be a power of 2 in 2..16");
  end
  if (GUARD_BLOCKS < 0 || GUARD_BLOCKS > 15) begin : g_bad_guard
    $fatal(1, "ipg_tx: GUARD_BLOCKS must be in 0..15");
  end

  localparam logic [3:0] GUARD_LAST = 4'(GUARD_BLOCKS - 1);

  tx_state_e  state;
  logic [3:0] guard_cnt;
  blk_class_e blk_class;
  ipg_entry_t push_entry;
  ipg_entry_t head;
  logic       push;
  logic       len_bad;
  logic       fifo_empty;
  logic       fifo_full_unused;
  logic       eligible;
  logic       insert;
  logic       unused_data_hi;

  assign blk_class = classify(encoded_tx_data, encoded_tx_hdr);

  assign push    = side.tx_ipg_valid && side.tx_ipg_ready;
  assign len_bad = (side.tx_ipg_len == 6'd0) || (side.tx_ipg_len > 6'd48);
  assign tx_ipg_len_err = push && len_bad;

  assign push_entry.is_null = (side.tx_ipg_len == 6'd0);
  assign push_entry.len     = (side.tx_ipg_len > 6'd48) ? 6'd48 : side.tx_ipg_len;
  assign push_entry.data    = side.tx_ipg_data[IPG_PAYLOAD_BITS-1:0];
  assign unused_data_hi     = ^side.tx_ipg_data[63:IPG_PAYLOAD_BITS];

  // A null word is still consumed by an eligible idle; it just emits nothing.
  assign eligible = (state == ST_GAP) && (blk_class == CLS_IDLE) && !fifo_empty;
  assign insert   = eligible && !head.is_null;

  ipg_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (push),
    .push_entry (push_entry),
    .pop        (eligible),
    .head       (head),
    .full       (fifo_full_unused),
    .empty      (fifo_empty),
    .ready      (side.tx_ipg_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ST_GAP;
      guard_cnt       <= '0;
      out_tx_data     <= IDLE_BLOCK;
      out_tx_hdr      <= HDR_CTRL;
      tx_ipg_inserted <= 1'b0;
      tx_ipg_count    <= '0;
    end else begin
      tx_ipg_inserted <= insert;
      if (insert) begin
        out_tx_data  <= ipg_block(IPG_BLOCK_TYPE, head.len, head.data);
        out_tx_hdr   <= HDR_CTRL;
        tx_ipg_count <= tx_ipg_count + 16'd1;
      end else begin
        out_tx_data <= encoded_tx_data;
        out_tx_hdr  <= encoded_tx_hdr;
      end

      // A corrupt header means framing is unknown; fall back to the gap.
      if (blk_class == CLS_BAD_HDR) begin
        state     <= ST_GAP;
        guard_cnt <= '0;
      end else begin
        case (state)
          ST_GAP: begin
            if (blk_class == CLS_START) state <= ST_FRAME;
          end
          ST_FRAME: begin
            if (blk_class == CLS_TERM) begin
              guard_cnt <= '0;
              state     <= (GUARD_BLOCKS > 0) ? ST_GUARD : ST_GAP;
            end
          end
          ST_GUARD: begin
            if (blk_class == CLS_START) begin
              state <= ST_FRAME;
            end else if (blk_class == CLS_IDLE) begin
              guard_cnt <= guard_cnt + 4'd1;
              if (guard_cnt == GUARD_LAST) state <= ST_GAP;
            end
          end
          default: state <= ST_GAP;
        endcase
      end
    end
  end

endmodule
